// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
// Optional build macro: SERIAL_ADD_SUB_EN (adds the sub input to serial_add_ctrl).
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full-adder cell used as the serial datapath; purely combinational.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks a WIDTH-bit operand pair LSB first.
// Optional build macro: SERIAL_ADD_SUB_EN adds input sub (a - b when sub=1).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-2:0] r_sh_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin is deliberately ignored in that mode.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    fa_cell u_fa (
        .i_a  (r_sh_a[0]),
        .i_b  (r_sh_b[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // Partial sum holds WIDTH-1 bits; the current cell output completes the word.
    assign w_sum_next = {w_s, r_sh_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_s  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= w_b_load;
                        r_carry <= w_c_load;
                        r_sh_s  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_sh_s  <= w_sum_next[WIDTH-1:1];
                    r_carry <= w_co;
                    if (r_cnt == CNT_LAST) begin
                        // Publish the result together with the done pulse.
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
